pong_scoreboard: RTL and testbench

Downstream consumer of the ping-pong game FSM's `score_state` code. Turns each new point award into a left/right score increment and detects match end at a configurable point total. Drives a 4-digit multiplexed seven-segment display showing both scores. Runs on the same fabric clock as the debouncer, ahead of the divided LED clock.

---
 rtl/pong_scoreboard.sv | 154 +++++++++++++++
 tb/tb_pong_scoreboard.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pong_scoreboard.sv
// Pong match scoreboard: award edge detection, BCD scores, win check and a
// 4-digit muxed seven-segment scan. Define PONG_DEUCE_EN for the win-by-two rule.
module pong_scoreboard #(
  parameter int WIN_POINTS = 11,
  parameter int SCAN_W     = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] score_state,
  input  logic       clear,
  output logic [6:0] score_l,
  output logic [6:0] score_r,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [6:0] seg,
  output logic [3:0] an
);

  // Side 0 is right, side 1 is left, matching the bit positions of winner/score_state.
  localparam int NUM_SIDES = 2;
  localparam logic [6:0] WIN7 = 7'(WIN_POINTS);
  localparam logic [6:0] MAX7 = 7'd99;

  typedef struct packed {
    logic [6:0] bin;
    logic [3:0] tens;
    logic [3:0] ones;
  } side_t;

  logic [1:0]                  prev_ss;
  logic [1:0]                  award;
  logic [NUM_SIDES-1:0]        inc;
  logic [NUM_SIDES-1:0]        win;
  logic [NUM_SIDES-1:0][6:0]   cur_bin;
  logic [NUM_SIDES-1:0][3:0]   cur_tens;
  logic [NUM_SIDES-1:0][3:0]   cur_ones;
  logic [NUM_SIDES-1:0][6:0]   nxt_bin;
  logic [SCAN_W+1:0]           scan;

  // A code counts only on the cycle it first appears; 11 is tracked but never awards.
  always_comb begin
    award = 2'b00;
    if ((score_state == 2'b01 || score_state == 2'b10) && score_state != prev_ss)
      award = score_state;
  end

  assign inc = award & {NUM_SIDES{~game_over & ~clear}};

  for (genvar i = 0; i < NUM_SIDES; i++) begin : g_side
    side_t q;
    side_t nxt;
    logic  bump;

    always_comb begin
      bump = inc[i] && (q.bin != MAX7);
      nxt  = q;
      if (bump) begin
        nxt.bin = q.bin + 7'd1;
        if (q.ones == 4'd9) begin
          nxt.ones = 4'd0;
          nxt.tens = q.tens + 4'd1;
        end else begin
          nxt.ones = q.ones + 4'd1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst || clear) q <= '0;
      else               q <= nxt;
    end

    assign cur_bin[i]  = q.bin;
    assign cur_tens[i] = q.tens;
    assign cur_ones[i] = q.ones;
    assign nxt_bin[i]  = nxt.bin;

`ifdef PONG_DEUCE_EN
    // Needs the target and a two-point lead; a 99 cap without a lead never decides.
    assign win[i] = bump && (nxt.bin >= WIN7) &&
                    ({1'b0, nxt.bin} >= {1'b0, nxt_bin[NUM_SIDES-1-i]} + 8'd2);
`else
    assign win[i] = bump && (nxt.bin == WIN7);
`endif
  end

  assign score_r = cur_bin[0];
  assign score_l = cur_bin[1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_ss   <= 2'b00;
      game_over <= 1'b0;
      winner    <= 2'b00;
    end else begin
      prev_ss <= score_state;
      if (clear) begin
        game_over <= 1'b0;
        winner    <= 2'b00;
      end else if (!game_over && |win) begin
        game_over <= 1'b1;
        winner    <= win;
      end
    end
  end

  // Two extra bits above the digit select give the slow game-over blink.
  always_ff @(posedge clk) begin
    if (!rst) scan <= '0;
    else      scan <= scan + 1'b1;
  end

  function automatic logic [6:0] seg_dec(input logic [3:0] d);
    case (d)
      4'd0:    seg_dec = 7'b1000000;
      4'd1:    seg_dec = 7'b1111001;
      4'd2:    seg_dec = 7'b0100100;
      4'd3:    seg_dec = 7'b0110000;
      4'd4:    seg_dec = 7'b0011001;
      4'd5:    seg_dec = 7'b0010010;
      4'd6:    seg_dec = 7'b0000010;
      4'd7:    seg_dec = 7'b1111000;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0010000;
      default: seg_dec = 7'h7F;
    endcase
  endfunction

  logic [1:0] sel;
  logic       side_sel;
  logic       is_tens;
  logic [3:0] digit;
  logic       blank;

  always_comb begin
    sel      = scan[SCAN_W-1 -: 2];
    side_sel = sel[1];
    is_tens  = sel[0];
    digit    = is_tens ? cur_tens[side_sel] : cur_ones[side_sel];
    blank    = (is_tens && cur_tens[side_sel] == 4'd0) ||
               (game_over && scan[SCAN_W+1] && !winner[side_sel]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      seg <= 7'h7F;
      an  <= 4'hF;
    end else begin
      seg <= blank ? 7'h7F : seg_dec(digit);
      an  <= ~(4'b0001 << sel);
    end
  end

endmodule

// File: tb/tb_pong_scoreboard.sv
// Scoreboard bench for pong_scoreboard: stimulus queues expectations, a negedge
// monitor pops score checks by cycle stamp and display checks by scan slot.
module tb_pong_scoreboard;
  localparam int SW = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] score_state = 2'b00;
  logic [6:0] score_l, score_r, seg;
  logic       game_over;
  logic [1:0] winner;
  logic [3:0] an;

  pong_scoreboard #(.WIN_POINTS(11), .SCAN_W(SW)) dut (
    .clk(clk), .rst(rst), .score_state(score_state), .clear(clear),
    .score_l(score_l), .score_r(score_r), .game_over(game_over), .winner(winner),
    .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         cyc;
    logic [6:0] sl, sr;
    logic       go;
    logic [1:0] win;
    logic       disp;
  } sc_t;

  typedef struct {
    string      name;
    int         deadline;
    logic [1:0] dig;
    int         blink;   // 0/1 = required blink bit, 2 = either
    logic [6:0] seg;
  } dc_t;

  sc_t sq[$];
  dc_t dq[$];
  int  cyc = 0, checks = 0, passed = 0;

  // Model of the scan slot whose digit is on the display this cycle.
  logic [SW+1:0] mscan = '0, mshown = '0;
  logic          shown_ok = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      mscan <= '0; shown_ok <= 1'b0;
    end else begin
      mscan <= mscan + 1'b1; mshown <= mscan; shown_ok <= 1'b1;
    end
  end

  always @(negedge clk) begin
    sc_t e;
    dc_t d;
    logic [3:0] ean;
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      e = sq.pop_front();
      checks++;
      if (score_l !== e.sl || score_r !== e.sr || game_over !== e.go || winner !== e.win ||
          (e.disp && (seg !== 7'h7F || an !== 4'hF)))
        $display("FAIL %s: got l=%0d r=%0d go=%b win=%b seg=%h an=%h, need l=%0d r=%0d go=%b win=%b%s",
                 e.name, score_l, score_r, game_over, winner, seg, an,
                 e.sl, e.sr, e.go, e.win, e.disp ? " seg=7f an=f" : "");
      else passed++;
    end
    if (dq.size() > 0) begin
      d = dq[0];
      if (cyc > d.deadline) begin
        void'(dq.pop_front());
        checks++;
        $display("FAIL %s: display slot never seen (digit %0d)", d.name, d.dig);
      end else if (shown_ok && mshown[SW-1 -: 2] == d.dig &&
                   (d.blink == 2 || mshown[SW+1] == d.blink[0])) begin
        void'(dq.pop_front());
        ean = ~(4'b0001 << d.dig);
        checks++;
        if (seg !== d.seg || an !== ean)
          $display("FAIL %s: got seg=%b an=%b, need seg=%b an=%b", d.name, seg, an, d.seg, ean);
        else passed++;
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic exp_sc(string nm, int dly, int sl, int sr, bit go, logic [1:0] w, bit disp = 1'b0);
    sc_t e;
    e.name = nm; e.cyc = cyc + dly; e.sl = 7'(sl); e.sr = 7'(sr);
    e.go = go; e.win = w; e.disp = disp;
    sq.push_back(e);
  endtask

  task automatic exp_dg(string nm, logic [1:0] dg, int blink, logic [6:0] s);
    dc_t e;
    e.name = nm; e.deadline = cyc + 400; e.dig = dg; e.blink = blink; e.seg = s;
    dq.push_back(e);
  endtask

  task automatic drain();
    int t = 0;
    while ((sq.size() > 0 || dq.size() > 0) && t < 2000) begin step(); t++; end
    if (t >= 2000) begin
      checks++;
      $display("FAIL drain: queues stuck sc=%0d dc=%0d", sq.size(), dq.size());
      sq.delete(); dq.delete();
    end
  endtask

  task automatic award(logic [1:0] s);
    score_state = s; step();
    score_state = 2'b00; step();
  endtask

  initial begin
    // Reset held 3 cycles, outputs blank until the first scan slot registers.
    step(3);
    rst = 1'b1;
    exp_sc("reset", 0, 0, 0, 0, 2'b00, 1'b1);
    exp_dg("rst_r_ones", 2'd0, 2, 7'b1000000);
    exp_dg("rst_r_tens", 2'd1, 2, 7'h7F);
    exp_dg("rst_l_ones", 2'd2, 2, 7'b1000000);
    exp_dg("rst_l_tens", 2'd3, 2, 7'h7F);
    drain();

    // A held level counts once.
    score_state = 2'b10;
    exp_sc("hold_first", 1, 1, 0, 0, 2'b00);
    step(50);
    exp_sc("hold_50", 0, 1, 0, 0, 2'b00);
    score_state = 2'b00; step();
    score_state = 2'b01; step();
    exp_sc("right_pulse", 0, 1, 1, 0, 2'b00);
    score_state = 2'b11; step(3);
    exp_sc("code11", 0, 1, 1, 0, 2'b00);
    score_state = 2'b10; step();
    exp_sc("11_to_10", 0, 2, 1, 0, 2'b00);
    score_state = 2'b01; step();
    exp_sc("10_to_01", 0, 2, 2, 0, 2'b00);
    score_state = 2'b10; step();
    exp_sc("01_to_10", 0, 3, 2, 0, 2'b00);
    score_state = 2'b00; step();

    // BCD carry into the tens digit.
    repeat (8) award(2'b01);
    exp_sc("bcd_ten", 0, 3, 10, 0, 2'b00);
    exp_dg("bcd_r_ones", 2'd0, 2, 7'b1000000);
    exp_dg("bcd_r_tens", 2'd1, 2, 7'b1111001);
    exp_dg("bcd_l_ones", 2'd2, 2, 7'b0110000);
    exp_dg("bcd_l_tens", 2'd3, 2, 7'h7F);
    drain();

    // Reset mid-match drops everything.
    rst = 1'b0; step(); rst = 1'b1;
    exp_sc("mid_reset", 0, 0, 0, 0, 2'b00, 1'b1);
    drain();

    // Left wins on the 11th point; later awards ignored.
    repeat (10) award(2'b10);
    exp_sc("ten_l", 0, 10, 0, 0, 2'b00);
    score_state = 2'b10;
    exp_sc("pre_win", 0, 10, 0, 0, 2'b00);
    step();
    exp_sc("win_l", 0, 11, 0, 1, 2'b10);
    score_state = 2'b00; step();
    award(2'b10);
    award(2'b01);
    exp_sc("frozen", 0, 11, 0, 1, 2'b10);
    exp_dg("blink_r_off", 2'd0, 1, 7'h7F);
    exp_dg("blink_l_on", 2'd2, 1, 7'b1111001);
    exp_dg("blink_l_tens", 2'd3, 1, 7'b1111001);
    exp_dg("blink_r_back", 2'd0, 0, 7'b1000000);
    drain();

    // Clear held high keeps scores at zero.
    clear = 1'b1; score_state = 2'b10;
    exp_sc("clear", 1, 0, 0, 0, 2'b00);
    step(2);
    exp_sc("clear_hold", 0, 0, 0, 0, 2'b00);
    clear = 1'b0; score_state = 2'b00; step();

`ifdef PONG_DEUCE_EN
    repeat (10) begin award(2'b10); award(2'b01); end
    exp_sc("deuce_10_10", 0, 10, 10, 0, 2'b00);
    award(2'b10);
    exp_sc("deuce_11_10", 0, 11, 10, 0, 2'b00);
    award(2'b01);
    award(2'b10);
    exp_sc("deuce_12_11", 0, 12, 11, 0, 2'b00);
    award(2'b10);
    exp_sc("deuce_13_11", 0, 13, 11, 1, 2'b10);
`else
    repeat (10) begin award(2'b10); award(2'b01); end
    award(2'b01);
    exp_sc("win_r", 0, 10, 11, 1, 2'b01);
    exp_dg("blink_l_off", 2'd2, 1, 7'h7F);
    exp_dg("blink_r_on", 2'd0, 1, 7'b1111001);
`endif
    drain();
    clear = 1'b1; step(); clear = 1'b0;

    // Clear beats a simultaneous award, and the held code stays spent.
    repeat (5) begin award(2'b10); award(2'b01); end
    exp_sc("five_five", 0, 5, 5, 0, 2'b00);
    clear = 1'b1; score_state = 2'b01; step();
    clear = 1'b0;
    exp_sc("collide", 0, 0, 0, 0, 2'b00);
    step(5);
    exp_sc("collide_hold", 0, 0, 0, 0, 2'b00);
    score_state = 2'b00; step();
    award(2'b01);
    exp_sc("after_collide", 0, 0, 1, 0, 2'b00);
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
